ste_dma_chanmodel: RTL and testbench

Parametrised multi-channel successor to the single-channel STE floppy/ACSI DMA bench model. It sits between the GSTMCU DMA pins (FCS_N, RDY_N_I/RDY_N_O, A1) and CHANNELS device-side word streams, and holds one FIFO per channel. It requests fixed-length bursts from the MCU in either direction and exposes a small CPU register pair for channel/direction selection, PIO and status. Used in the STE testbench top in place of the fixed dma_tb instance.

---
 rtl/ste_dma_pkg.sv | 20 ++
 rtl/dma_chan_fifo.sv | 49 ++++
 rtl/ste_dma_chanmodel.sv | 168 ++++++++++++++++
 tb/tb_ste_dma_chanmodel.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ste_dma_pkg.sv
// Shared constants and FSM encoding for the multi-channel STE DMA bench model.
package ste_dma_pkg;

    localparam int unsigned CTL_CHAN_LSB = 0;
    localparam int unsigned CTL_DIR      = 8;
    localparam int unsigned CTL_CLEAR    = 14;
    localparam int unsigned CTL_FLUSH    = 15;

    localparam int unsigned ST_ACTIVE    = 9;
    localparam int unsigned ST_OVF       = 10;
    localparam int unsigned ST_UDR       = 11;
    localparam int unsigned ST_DONE      = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } dma_state_e;

endpackage

// File: rtl/dma_chan_fifo.sv
// Per-channel word FIFO: read-first, no bypass, with level/free reporting and flush.
module dma_chan_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk32,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [15:0]              din,
    output logic [15:0]              dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   free,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [15:0]   mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          do_push;
    logic          do_pop;

    assign level   = wptr - rptr;
    assign free    = LW'(DEPTH) - level;
    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk32) begin
        if (reset || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + LW'(1);
            if (do_pop)  rptr <= rptr + LW'(1);
        end
    end

    always_ff @(posedge clk32) begin
        if (do_push && !flush) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ste_dma_chanmodel.sv
// Multi-channel STE DMA bench model: per-channel FIFOs, MCU burst requester and
// CPU control/status/data register pair.
module ste_dma_chanmodel
    import ste_dma_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned BURST    = 8
) (
    input  logic                    clk32,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic                    FCS_N,
    input  logic                    RW,
    input  logic                    A1,
    input  logic [15:0]             DIN,
    output logic [15:0]             DOUT,
    input  logic                    RDY_I,
    output logic                    RDY_O,
    input  logic [CHANNELS-1:0]     dev_in_valid,
    output logic [CHANNELS-1:0]     dev_in_ready,
    input  logic [16*CHANNELS-1:0]  dev_in_data,
    output logic [CHANNELS-1:0]     dev_out_valid,
    input  logic [CHANNELS-1:0]     dev_out_ready,
    output logic [16*CHANNELS-1:0]  dev_out_data,
    output logic                    irq
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = $clog2(BURST);

    dma_state_e          state_q, state_d;
    logic [2:0]          chan_q;
    logic [CHANNELS-1:0] dir_q;
    logic                ovf_q, udr_q, done_q;
    logic [CW-1:0]       cnt_q;

    logic [CHANNELS-1:0] is_sel, f_push, f_pop, f_flush, f_full, f_empty;
    logic [15:0]         f_din   [CHANNELS];
    logic [15:0]         f_dout  [CHANNELS];
    logic [LW-1:0]       f_level [CHANNELS];
    logic [LW-1:0]       f_free  [CHANNELS];

    logic          ctl_wr, data_wr, data_rd, xfer, flush_sel, clear_err;
    logic          mcu_push, mcu_pop, start, ovf_evt, udr_evt;
    logic          sel_dir, sel_full, sel_empty;
    logic [15:0]   sel_head, status, rd_data;
    logic [LW-1:0] sel_level, sel_free;

    assign ctl_wr    = clk_en && !FCS_N && !RW && A1;
    assign data_wr   = clk_en && !FCS_N && !RW && !A1;
    assign data_rd   = clk_en && !FCS_N && RW && !A1;
    assign xfer      = clk_en && (state_q == REQ) && !RDY_I;
    assign flush_sel = ctl_wr && DIN[CTL_FLUSH];
    assign clear_err = ctl_wr && DIN[CTL_CLEAR];
    assign mcu_push  = data_wr || (xfer && sel_dir);
    assign mcu_pop   = data_rd || (xfer && !sel_dir);
    assign udr_evt   = mcu_pop && sel_empty;
    assign start     = sel_dir ? (sel_free >= LW'(BURST)) : (sel_level >= LW'(BURST));

    always_comb begin
        sel_dir   = 1'b0;
        sel_full  = 1'b0;
        sel_empty = 1'b1;
        sel_head  = '0;
        sel_level = '0;
        sel_free  = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (chan_q == 3'(c)) begin
                sel_dir   = dir_q[c];
                sel_full  = f_full[c];
                sel_empty = f_empty[c];
                sel_head  = f_dout[c];
                sel_level = f_level[c];
                sel_free  = f_free[c];
            end
        end
    end

    // MCU access to the selected channel takes the FIFO port; device side backs off that cycle.
    always_comb begin
        ovf_evt = mcu_push && sel_full;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            is_sel[c]        = (chan_q == 3'(c));
            dev_in_ready[c]  = !f_full[c] && (!dir_q[c] || !is_sel[c]) && !(is_sel[c] && mcu_push);
            dev_out_valid[c] = !f_empty[c] && dir_q[c] && !(is_sel[c] && mcu_pop);
            f_push[c]        = (is_sel[c] && mcu_push) || (dev_in_valid[c] && dev_in_ready[c]);
            f_din[c]         = (is_sel[c] && mcu_push) ? DIN : dev_in_data[16*c +: 16];
            f_pop[c]         = (is_sel[c] && mcu_pop) || (dev_out_valid[c] && dev_out_ready[c]);
            f_flush[c]       = is_sel[c] && flush_sel;
            dev_out_data[16*c +: 16] = f_dout[c];
            if (dev_in_valid[c] && f_full[c] && (!dir_q[c] || !is_sel[c])) ovf_evt = 1'b1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        dma_chan_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk32 (clk32),
            .reset (reset),
            .flush (f_flush[c]),
            .push  (f_push[c]),
            .pop   (f_pop[c]),
            .din   (f_din[c]),
            .dout  (f_dout[c]),
            .level (f_level[c]),
            .free  (f_free[c]),
            .full  (f_full[c]),
            .empty (f_empty[c])
        );
    end

    // A control write in IDLE defers the burst start so chan/dir never change under a new burst.
    always_comb begin
        state_d = state_q;
        if (clk_en) begin
            unique case (state_q)
                IDLE:    if (start && !ctl_wr) state_d = REQ;
                REQ:     if (xfer && (cnt_q == CW'(BURST - 1))) state_d = GAP;
                GAP:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        if (flush_sel) state_d = IDLE;
    end

    always_ff @(posedge clk32) begin
        if (reset) begin
            state_q <= IDLE;
            chan_q  <= '0;
            dir_q   <= '0;
            ovf_q   <= 1'b0;
            udr_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q != REQ) || flush_sel) cnt_q <= '0;
            else if (xfer)                     cnt_q <= cnt_q + CW'(1);
            if (ctl_wr && (state_q == IDLE)) begin
                chan_q <= DIN[CTL_CHAN_LSB +: 3];
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    if (DIN[CTL_CHAN_LSB +: 3] == 3'(c)) dir_q[c] <= DIN[CTL_DIR];
                end
            end
            ovf_q  <= ovf_evt || (ovf_q && !clear_err);
            udr_q  <= udr_evt || (udr_q && !clear_err);
            done_q <= ((state_q == REQ) && (state_d == GAP)) ||
                      (done_q && !clear_err && !((state_q == IDLE) && (state_d == REQ)));
        end
    end

    always_comb begin
        status = '0;
        status[CTL_CHAN_LSB +: 3] = chan_q;
        status[CTL_DIR]           = sel_dir;
        status[ST_ACTIVE]         = (state_q != IDLE);
        status[ST_OVF]            = ovf_q;
        status[ST_UDR]            = udr_q;
        status[ST_DONE]           = done_q;
    end

    assign rd_data = A1 ? status : sel_head;
    assign DOUT    = (!RDY_I && !sel_dir) ? sel_head :
                     (!FCS_N && RW)       ? rd_data  : '0;
    assign RDY_O   = (state_q != REQ);
    assign irq     = ovf_q || udr_q || done_q;

endmodule

// File: tb/tb_ste_dma_chanmodel.sv
// Directed bench for ste_dma_chanmodel (2 channels, DEPTH 16, BURST 8).
module tb_ste_dma_chanmodel;

    localparam int unsigned CH = 2;

    logic              clk32 = 1'b0;
    logic              reset, clk_en, FCS_N, RW, A1, RDY_I;
    logic [15:0]       DIN, DOUT;
    logic              RDY_O, irq;
    logic [CH-1:0]     dev_in_valid, dev_in_ready, dev_out_valid, dev_out_ready;
    logic [16*CH-1:0]  dev_in_data, dev_out_data;
    int                total = 0;
    int                bad = 0;
    logic [15:0]       v;

    always #5 clk32 = ~clk32;

    ste_dma_chanmodel #(.CHANNELS(CH), .DEPTH(16), .BURST(8)) dut (
        .clk32         (clk32),
        .reset         (reset),
        .clk_en        (clk_en),
        .FCS_N         (FCS_N),
        .RW            (RW),
        .A1            (A1),
        .DIN           (DIN),
        .DOUT          (DOUT),
        .RDY_I         (RDY_I),
        .RDY_O         (RDY_O),
        .dev_in_valid  (dev_in_valid),
        .dev_in_ready  (dev_in_ready),
        .dev_in_data   (dev_in_data),
        .dev_out_valid (dev_out_valid),
        .dev_out_ready (dev_out_ready),
        .dev_out_data  (dev_out_data),
        .irq           (irq)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk32);
        #1;
    endtask

    task automatic mtick();
        clk_en = 1'b1;
        clk1();
        clk_en = 1'b0;
        repeat (3) clk1();
    endtask

    task automatic ctl_write(input logic [15:0] d);
        FCS_N = 1'b0; RW = 1'b0; A1 = 1'b1; DIN = d;
        mtick();
        FCS_N = 1'b1; RW = 1'b1;
    endtask

    task automatic status_rd(output logic [15:0] s);
        FCS_N = 1'b0; RW = 1'b1; A1 = 1'b1;
        #1 s = DOUT;
        FCS_N = 1'b1;
        #1;
    endtask

    task automatic dev_push(input int unsigned c, input logic [15:0] d);
        dev_in_valid[c] = 1'b1;
        dev_in_data[16*c +: 16] = d;
        clk1();
        dev_in_valid[c] = 1'b0;
    endtask

    task automatic strobe(output logic [15:0] d);
        RDY_I = 1'b0;
        #1 d = DOUT;
        mtick();
        RDY_I = 1'b1;
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b0; FCS_N = 1'b1; RW = 1'b1; A1 = 1'b0; RDY_I = 1'b1;
        DIN = '0; dev_in_valid = '0; dev_in_data = '0; dev_out_ready = '0;
        repeat (3) mtick();
        reset = 1'b0;
        repeat (10) mtick();
        chk("rst_rdy", 16'(RDY_O), 16'h0001);
        chk("rst_dout", DOUT, 16'h0000);
        chk("rst_irq", 16'(irq), 16'h0000);
        status_rd(v); chk("rst_status", v, 16'h0000);

        // ch1 dev->mem burst
        ctl_write(16'h0001);
        chk("b0_ready", 16'(dev_in_ready[1]), 16'h0001);
        for (int i = 0; i < 8; i++) dev_push(1, 16'h1000 + 16'(i));
        chk("b0_rdy_pre", 16'(RDY_O), 16'h0001);
        mtick();
        chk("b0_rdy_req", 16'(RDY_O), 16'h0000);
        for (int i = 0; i < 8; i++) begin
            strobe(v);
            chk($sformatf("b0_word%0d", i), v, 16'h1000 + 16'(i));
        end
        chk("b0_rdy_end", 16'(RDY_O), 16'h0001);
        mtick();
        status_rd(v); chk("b0_status", v, 16'h1001);
        chk("b0_irq", 16'(irq), 16'h0001);
        mtick();
        chk("b0_idle_rdy", 16'(RDY_O), 16'h0001);

        // ch0 mem->dev burst
        ctl_write(16'h0100);
        mtick();
        chk("b1_rdy_req", 16'(RDY_O), 16'h0000);
        status_rd(v); chk("b1_status", v, 16'h0300);
        for (int i = 0; i < 8; i++) begin
            DIN = 16'hA5A0 + 16'(i);
            strobe(v);
            chk($sformatf("b1_dout%0d", i), v, 16'h0000);
        end
        chk("b1_rdy_end", 16'(RDY_O), 16'h0001);
        dev_out_ready[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b1_oval%0d", i), 16'(dev_out_valid[0]), 16'h0001);
            chk($sformatf("b1_odat%0d", i), dev_out_data[15:0], 16'hA5A0 + 16'(i));
            clk1();
        end
        chk("b1_oval_empty", 16'(dev_out_valid[0]), 16'h0000);
        dev_out_ready[0] = 1'b0;
        ctl_write(16'h8000);
        ctl_write(16'h4001);
        status_rd(v); chk("sel1_status", v, 16'h0001);
        chk("sel1_irq", 16'(irq), 16'h0000);

        // overflow on ch1
        for (int i = 0; i < 16; i++) dev_push(1, 16'h2000 + 16'(i));
        chk("ovf_ready_full", 16'(dev_in_ready[1]), 16'h0000);
        dev_push(1, 16'hDEAD);
        status_rd(v); chk("ovf_status", v, 16'h0401);
        chk("ovf_irq", 16'(irq), 16'h0001);
        ctl_write(16'h4001);
        chk("clr_irq", 16'(irq), 16'h0000);
        status_rd(v); chk("clr_status", v, 16'h0001);

        // chan change ignored during burst
        mtick();
        chk("b2_rdy_req", 16'(RDY_O), 16'h0000);
        ctl_write(16'h0000);
        status_rd(v); chk("b2_status_locked", v, 16'h0201);
        for (int i = 0; i < 8; i++) begin
            strobe(v);
            chk($sformatf("b2_word%0d", i), v, 16'h2000 + 16'(i));
        end
        chk("b2_rdy_end", 16'(RDY_O), 16'h0001);
        chk("b2_irq", 16'(irq), 16'h0001);
        mtick();
        status_rd(v); chk("b2_status_done", v, 16'h1001);

        // flush after 3 words
        mtick();
        chk("b3_rdy_req", 16'(RDY_O), 16'h0000);
        status_rd(v); chk("b3_status", v, 16'h0201);
        for (int i = 0; i < 3; i++) begin
            strobe(v);
            chk($sformatf("b3_word%0d", i), v, 16'h2008 + 16'(i));
        end
        ctl_write(16'h8001);
        chk("fl_rdy", 16'(RDY_O), 16'h0001);
        status_rd(v); chk("fl_status", v, 16'h0001);
        mtick();
        chk("fl_rdy_idle", 16'(RDY_O), 16'h0001);

        // PIO round trip and underrun
        FCS_N = 1'b0; RW = 1'b0; A1 = 1'b0; DIN = 16'hBEEF;
        mtick();
        RW = 1'b1;
        #1 chk("pio_read", DOUT, 16'hBEEF);
        mtick();
        #1 chk("pio_empty", DOUT, 16'h0000);
        mtick();
        FCS_N = 1'b1;
        status_rd(v); chk("udr_status", v, 16'h0801);
        chk("udr_irq", 16'(irq), 16'h0001);

        // reset mid-burst
        for (int i = 0; i < 8; i++) dev_push(1, 16'h3000 + 16'(i));
        mtick();
        chk("b4_rdy_req", 16'(RDY_O), 16'h0000);
        strobe(v); chk("b4_word0", v, 16'h3000);
        reset = 1'b1;
        mtick();
        reset = 1'b0;
        chk("rst2_rdy", 16'(RDY_O), 16'h0001);
        chk("rst2_irq", 16'(irq), 16'h0000);
        status_rd(v); chk("rst2_status", v, 16'h0000);
        mtick();
        chk("rst2_rdy_idle", 16'(RDY_O), 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
